spi_cmd_tx: RTL
===============

Name: spi_cmd_tx

Overview:
- SPI transmitter (master) for the 24-bit {x, y, data} command frame used by the board's SPI command receiver.
- Accepts one command through a valid/ready handshake and serialises it MSB-first, bit 23 first.
- Generates SPI_CLK, SPI_CS and SPI_DATA from the system clock so that a receiver shifting on SPI_CLK falling edges and latching on SPI_CS rising edge captures exactly 24 bits.
- Sits between game logic (paddle/snake position producer) and the off-chip or loopback SPI link.

Parameters:
- HALF_DIV, 4, system clocks per SPI_CLK half-period; must be >= 1.
- GAP_CYCLES, 8, minimum system clocks SPI_CS stays high between frames; must be >= 1.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- RESET_N  input  1  reset, asynchronous assert, active-low.
- cmd_x  input  8  x field, frame bits 23:16.
- cmd_y  input  8  y field, frame bits 15:8.
- cmd_data  input  8  data field, frame bits 7:0.
- cmd_valid  input  1  command present on cmd_*.
- cmd_ready  output  1  holding register empty; command accepted on a cycle where cmd_valid and cmd_ready are both high.
- busy  output  1  high while a frame is in progress (SPI_CS low) or during the inter-frame gap.
- done  output  1  one-cycle pulse on the cycle SPI_CS returns high.
- SPI_CLK  output  1  serial clock, idle low.
- SPI_CS  output  1  chip select, active-low, idle high.
- SPI_DATA  output  1  serial data (MOSI).

Behaviour:
- Reset: while RESET_N is low, SPI_CS=1, SPI_CLK=0, SPI_DATA=0, done=0, busy=0 and cmd_ready=0. Holding register is emptied. cmd_ready=1 from the first clock after reset is released. All outputs are registered.
- Buffering: one 24-bit holding register plus a 24-bit shift register. A command is accepted while a frame is shifting, so back-to-back frames are separated only by the gap. cmd_ready falls on the cycle after acceptance and rises on the cycle the holding register is moved into the shifter.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL, GAP.
- IDLE: if the holding register is full, load it into the shifter, drive SPI_CS=0 and go to LEAD. Acceptance and load may occur on consecutive cycles (1-cycle latency from acceptance to SPI_CS fall).
- LEAD: hold SPI_CLK=0 for HALF_DIV cycles, then go to HIGH.
- HIGH: on entry, SPI_CLK=1 and SPI_DATA=shifter[23]. Hold for HALF_DIV cycles, then go to LOW.
- LOW: on entry, SPI_CLK=0; this falling edge is the receiver sample point. Shift the shifter left by 1 and increment the 5-bit bit counter. After HALF_DIV cycles: if the counter is 24, go to TRAIL; else go to HIGH.
- TRAIL: SPI_CLK stays 0 for HALF_DIV cycles, then SPI_CS=1, done=1 for 1 cycle, SPI_DATA=0, go to GAP.
- GAP: SPI_CS=1 for GAP_CYCLES, then return to IDLE. If the holding register is full, IDLE loads on its next cycle.
- Exactly 24 SPI_CLK falling edges per frame. No SPI_CLK edges while SPI_CS is high.
- SPI_CS is low for exactly 50*HALF_DIV cycles. Frame period is 50*HALF_DIV + GAP_CYCLES + 1 cycles (+1 for the IDLE load cycle).
- SPI_DATA changes only on SPI_CLK rising edges, so it is stable for HALF_DIV cycles before each falling edge.
- Simultaneous events: acceptance in the same cycle as the holding-to-shifter transfer is allowed only if the holding register is emptied that cycle; cmd_ready reflects registered state, so no combinational path from cmd_valid.
- cmd_* are sampled only on acceptance; later changes have no effect.
- Reset mid-frame: SPI_CS rises asynchronously and the partial frame is aborted. The receiver may latch a partial value. No done pulse is produced, and the holding register is discarded. Producers re-send after reset.
- Divider and gap counters are sized by $clog2 of the parameter, with a minimum width of 1.

Decomposition:
- Shared package spi_cmd_pkg: FRAME_BITS=24, field MSB/LSB constants (X 23:16, Y 15:8, DATA 7:0), and the FSM state enum.
- Natural sub-module: spi_clk_div, a half-period tick counter with a restart input. The FSM, shifter and holding register stay in spi_cmd_tx.

Test Plan:
- Single frame: x=8'hA5, y=8'h3C, data=8'h81, HALF_DIV=4 -> a reference receiver model capturing on SPI_CLK falling edges latches 24'hA53C81 at SPI_CS rise. Exactly 24 falling edges; SPI_CS low for 200 cycles; done pulses once.
- Back-to-back: offer 24'h010203 then 24'hFFFFFF with cmd_valid held high -> both accepted with no drops. Second SPI_CS fall occurs exactly GAP_CYCLES+1 cycles after the first SPI_CS rise; receiver sees 010203 then FFFFFF.
- Backpressure: offer a third command while one is shifting and one is held -> cmd_ready=0 until the held command loads. cmd_* changed while cmd_ready=0 does not corrupt the captured values.
- Setup check: at every SPI_CLK falling edge, SPI_DATA unchanged for the previous HALF_DIV cycles. SPI_DATA=0 and SPI_CLK=0 while SPI_CS=1. Repeat with HALF_DIV=1 and GAP_CYCLES=1.
- Reset mid-frame: assert RESET_N=0 after bit 10 -> same-delta SPI_CS=1, SPI_CLK=0, no done. After release, cmd_ready=1 and frame 24'h123456 transmits correctly.
- Edge patterns: 24'h000000 and 24'h800001 -> SPI_DATA is high only on bits 23 and 0 for the second pattern; receiver captures both frames exactly.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Shared constants for the SPI command transmitter. Covers the
//               24-bit {x, y, data} frame layout, the transmitter state
//               encoding and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    // Frame layout: x in the top byte, then y, then data.
    localparam int c_FRAME_BITS = 24;
    localparam int c_X_MSB      = 23;
    localparam int c_X_LSB      = 16;
    localparam int c_Y_MSB      = 15;
    localparam int c_Y_LSB      = 8;
    localparam int c_DATA_MSB   = 7;
    localparam int c_DATA_LSB   = 0;

    // 5-bit bit counter and its terminal value (all 24 bits shifted out).
    localparam int             c_BIT_CNT_W    = 5;
    localparam logic [4:0]     c_BIT_CNT_LAST = 5'd24;

    // Transmitter state encoding.
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_LEAD  = 3'd1;
    localparam state_t c_ST_HIGH  = 3'd2;
    localparam state_t c_ST_LOW   = 3'd3;
    localparam state_t c_ST_TRAIL = 3'd4;
    localparam state_t c_ST_GAP   = 3'd5;

    // Width of a counter holding 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Half-period tick generator for the SPI clock. Counts
//               HALF_DIV system clocks and asserts o_tick on the last one.
//               i_restart holds the count at zero so that the first interval
//               after a restart is a full HALF_DIV cycles long.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               i_restart - force count back to zero
//               o_tick    - high on the final cycle of each half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
    import spi_cmd_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                 c_CNT_W   = cnt_width(HALF_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(HALF_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Wraps on its own at the end of each half-period, so consecutive
    // HIGH/LOW phases need no explicit restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_CNT_MAX)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/spi_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_tx
// Description : SPI master for the 24-bit {x, y, data} command frame. It
//               accepts one command over a valid/ready handshake into a
//               holding register and serialises it MSB first. A second
//               command may be accepted while the first is shifting, so
//               back-to-back frames are separated only by the CS gap.
// Ports       : CLOCK_50  - system clock
//               RESET_N   - asynchronous active-low reset
//               cmd_x     - frame bits 23:16
//               cmd_y     - frame bits 15:8
//               cmd_data  - frame bits 7:0
//               cmd_valid - command present on cmd_*
//               cmd_ready - holding register empty
//               busy      - frame in progress or inter-frame gap
//               done      - one-cycle pulse as SPI_CS returns high
//               SPI_CLK   - serial clock, idle low
//               SPI_CS    - chip select, active low
//               SPI_DATA  - serial data (MOSI)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_tx
    import spi_cmd_pkg::*;
#(
    parameter int HALF_DIV   = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       SPI_CLK,
    output logic       SPI_CS,
    output logic       SPI_DATA
);

    localparam int                 c_GAP_W   = cnt_width(GAP_CYCLES);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [c_FRAME_BITS-1:0] r_hold;
    logic                    r_hold_full;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [c_BIT_CNT_W-1:0]  r_bit_cnt;
    logic [c_GAP_W-1:0]      r_gap_cnt;
    logic                    r_cmd_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_spi_clk;
    logic                    r_spi_cs;
    logic                    r_spi_data;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic [c_FRAME_BITS-1:0] w_cmd_frame;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_hold_full_nxt;
    logic                    w_tick;
    logic                    w_restart;
    logic                    w_last_bit;
    logic                    w_gap_last;

    always_comb begin
        w_cmd_frame                        = '0;
        w_cmd_frame[c_X_MSB:c_X_LSB]       = cmd_x;
        w_cmd_frame[c_Y_MSB:c_Y_LSB]       = cmd_y;
        w_cmd_frame[c_DATA_MSB:c_DATA_LSB] = cmd_data;
    end

    // cmd_ready is registered and equals "holding register empty", so an
    // acceptance can never coincide with a load of the same register.
    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_load     = (r_state == c_ST_IDLE) && r_hold_full;
    assign w_last_bit = (r_bit_cnt == c_BIT_CNT_LAST);
    assign w_gap_last = (r_gap_cnt == c_GAP_MAX);

    always_comb begin
        w_hold_full_nxt = r_hold_full;
        if (w_accept) begin
            w_hold_full_nxt = 1'b1;
        end else if (w_load) begin
            w_hold_full_nxt = 1'b0;
        end
    end

    // The divider is held at zero while idle so the LEAD phase after a load
    // always lasts a full half-period.
    assign w_restart = (r_state == c_ST_IDLE);

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (r_hold_full) w_state_nxt = c_ST_LEAD;
            c_ST_LEAD:  if (w_tick)      w_state_nxt = c_ST_HIGH;
            c_ST_HIGH:  if (w_tick)      w_state_nxt = c_ST_LOW;
            c_ST_LOW:   if (w_tick)      w_state_nxt = w_last_bit ? c_ST_TRAIL : c_ST_HIGH;
            c_ST_TRAIL: if (w_tick)      w_state_nxt = c_ST_GAP;
            c_ST_GAP:   if (w_gap_last)  w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control: state, handshake, busy
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= c_ST_IDLE;
            r_hold_full <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_cmd_ready <= !w_hold_full_nxt;
            r_busy      <= (w_state_nxt != c_ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: holding register, shifter, bit and gap counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hold    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_hold <= w_cmd_frame;
            end

            if (w_load) begin
                r_shift   <= r_hold;
                r_bit_cnt <= '0;
            end else if ((r_state == c_ST_HIGH) && w_tick) begin
                // Entering LOW: the receiver samples on this falling edge,
                // so the next bit is moved up only now.
                r_shift   <= {r_shift[c_FRAME_BITS-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if ((r_state == c_ST_TRAIL) && w_tick) begin
                r_gap_cnt <= '0;
            end else if ((r_state == c_ST_GAP) && !w_gap_last) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI pins and done pulse, all updated on state transitions
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_spi_cs   <= 1'b1;
            r_spi_clk  <= 1'b0;
            r_spi_data <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_hold_full) begin
                        r_spi_cs <= 1'b0;
                    end
                end
                c_ST_LEAD: begin
                    if (w_tick) begin
                        r_spi_clk  <= 1'b1;
                        r_spi_data <= r_shift[c_FRAME_BITS-1];
                    end
                end
                c_ST_HIGH: begin
                    if (w_tick) begin
                        r_spi_clk <= 1'b0;
                    end
                end
                c_ST_LOW: begin
                    // After the 24th falling edge the clock stays low and
                    // the data pin keeps the last bit through TRAIL.
                    if (w_tick && !w_last_bit) begin
                        r_spi_clk  <= 1'b1;
                        r_spi_data <= r_shift[c_FRAME_BITS-1];
                    end
                end
                c_ST_TRAIL: begin
                    if (w_tick) begin
                        r_spi_cs   <= 1'b1;
                        r_spi_data <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign SPI_CLK   = r_spi_clk;
    assign SPI_CS    = r_spi_cs;
    assign SPI_DATA  = r_spi_data;

endmodule
`default_nettype wire
